nibble_entry_ctrl: RTL
======================

# nibble_entry_ctrl

Sequencer and arbiter for the 16-bit nibble-loadable display/operand register. It owns that register's `check`, `sw` and `in` controls, and shares the register between two requesters: a manual nibble-by-nibble entry session driven by debounced pushbuttons, and an external whole-word loader with a ready/valid handshake. Between operations it holds the register value by feeding the register output back in whole-word mode.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 100000: cycles a synchronized button level must stay stable before it is accepted.
- `TIMEOUT_CYCLES`, default 50000000: idle cycles allowed inside an entry session before it is abandoned.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `btn_start` in 1: raw pushbutton; opens an entry session.
- `btn_next` in 1: raw pushbutton; writes the current nibble and advances.
- `btn_abort` in 1: raw pushbutton; ends the session without further writes.
- `ext_valid` in 1: external word load request.
- `ext_data` in 16: external word.
- `ext_ready` out 1: external word accepted this cycle.
- `x_fb` in 16: current register value.
- `check` out 1: register mode; 0 = whole-word load from `in`, 1 = nibble write.
- `sw` out 2: nibble index driven to the register.
- `word_out` out 16: drives the register's `in`.
- `busy` out 1: entry session active.
- `nib_idx` out 2: next nibble to be written.
- `done` out 1: one-cycle pulse when the 4th nibble is written.
- `timeout` out 1: one-cycle pulse when a session is abandoned on timeout.

## Operation

- Each button passes through its own debouncer:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal synchronized samples.
  - A 0→1 change of the debounced level produces a one-cycle pulse (`start_p`, `next_p`, `abort_p`).
- Default outputs in every state: `check`=0, `sw`=`nib_idx`, `word_out`=`x_fb`. This holds the register.
- FSM states are IDLE, ENTRY and DONE.
- IDLE:
  - `ext_ready` = `ext_valid`.
  - If `ext_valid`: `word_out`=`ext_data`, so the register loads it at the next edge. Stay in IDLE.
  - Else if `start_p`: go to ENTRY, set `nib_idx`=0, clear the timeout counter.
  - `ext_valid` has priority over `start_p`. A `start_p` in the same cycle is dropped.
- ENTRY:
  - `busy`=1 and `ext_ready`=0. External requests stall and must hold `ext_valid`/`ext_data`.
  - If `abort_p`: go to IDLE. No write. Nibbles already written stay in the register.
  - Else if `next_p`:
    - Drive `check`=1, `sw`=`nib_idx` for exactly that cycle, and clear the timeout counter.
    - If `nib_idx`=3, go to DONE; otherwise increment `nib_idx`.
  - Else if the timeout counter equals `TIMEOUT_CYCLES`-1: pulse `timeout`, go to IDLE.
  - Else increment the timeout counter.
  - `abort_p` beats `next_p` in the same cycle. `next_p` beats timeout in the same cycle.
- DONE: pulse `done`, reset `nib_idx` to 0, go to IDLE. `ext_ready`=0 in this cycle.
- `next_p` and `abort_p` are ignored in IDLE. `start_p` is ignored in ENTRY and DONE.
- The nibble value itself is the register's own `switches` port. This block only times the write.

## Timing

- Reset state:
  - FSM in IDLE, `nib_idx`=0, all counters 0, debounced levels 0.
  - Outputs: `busy`=0, `done`=0, `timeout`=0, `check`=0, `sw`=0, `ext_ready`=0 (unless `ext_valid`).
  - `word_out`=`x_fb`.
- Reset asserted mid-session returns to IDLE immediately. No partial handshake survives.
- Button latency: a raw rising edge gives its pulse after 2 + `DEBOUNCE_CYCLES` cycles, ±1.
- The register updates at the edge that ends the cycle in which `check`=1 or `ext_ready`=1.
- External handshake: transfer happens on a cycle with `ext_valid` && `ext_ready`. `ext_ready` depends combinationally on `ext_valid` and state. Back-to-back transfers are allowed in IDLE.
- The timeout counter is wide enough for `TIMEOUT_CYCLES`-1 and saturates there.

## Structure

- Shared package `entry_pkg`:
  - `typedef enum logic [1:0] {IDLE, ENTRY, DONE} entry_state_t`.
  - Nibble count constant `NIBBLES = 4`.
- One sub-module, `btn_debounce`: parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn_raw`, `level`, `rise_p`. Instantiated three times.

## Test plan

Bench settings: `DEBOUNCE_CYCLES`=4, `TIMEOUT_CYCLES`=64, register model instantiated alongside.

1. Session: start press, then `switches`=C,3,A,5 with a next press each time → register reads 0x5A3C, `done` pulses once, `busy` falls after the 4th write.
2. Bounce: `btn_next` toggles every 2 cycles for 10 cycles, then stays high → exactly one nibble write.
3. Arbitration: `ext_valid`=1 with `ext_data`=0xBEEF in ENTRY → `ext_ready`=0 until after `done`. Then `ext_ready`=1 for one cycle and the register reads 0xBEEF.
4. Same-cycle priorities:
   - `ext_valid` and `start_p` together in IDLE → ext load happens, FSM stays in IDLE.
   - `abort_p` and `next_p` together in ENTRY → no write, FSM goes to IDLE.
5. Timeout: start press, then no activity for 64 cycles → `timeout` pulses, `busy`=0, register unchanged.
6. Reset mid-session after 2 nibbles → register=0, `nib_idx`=0. A new session writes from nibble 0.

Source files
------------

// File: rtl/entry_pkg.sv
// Shared types and constants for the nibble entry controller.
//   entry_state_t : sequencer state encoding
//   NIBBLES       : nibbles per register word
//   cnt_width()   : counter width needed to hold values 0..n-1 (min 1)
package entry_pkg;

  typedef enum logic [1:0] {IDLE, ENTRY, DONE} entry_state_t;

  localparam int NIBBLES = 4;
  localparam int NIB_W   = $clog2(NIBBLES);

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer followed by a stability counter.
//   clk, reset : clock, async active-high reset
//   btn_raw    : raw asynchronous button input
//   level      : debounced level, follows btn_raw after DEBOUNCE_CYCLES
//                consecutive equal synchronized samples
//   rise_p     : one-cycle pulse on a 0->1 change of level
module btn_debounce
  import entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_p
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise_p <= 1'b0;
    end else begin
      sync   <= {sync[0], btn_raw};
      rise_p <= 1'b0;
      // Any sample agreeing with the current level restarts the count, so
      // only an unbroken run of opposite samples can flip the level.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt    <= '0;
        level  <= sync[1];
        rise_p <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nibble_entry_ctrl.sv
// Sequencer/arbiter for the 16-bit nibble-loadable register. Shares the
// register between a pushbutton nibble-entry session and an external
// ready/valid whole-word loader; otherwise holds it via x_fb feedback.
//   btn_start/btn_next/btn_abort : raw pushbuttons (debounced here)
//   ext_valid/ext_data/ext_ready : external word load handshake
//   x_fb                         : current register value
//   check/sw/word_out            : register mode, nibble index, word input
//   busy/nib_idx/done/timeout    : session status
module nibble_entry_ctrl
  import entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_next,
  input  logic        btn_abort,
  input  logic        ext_valid,
  input  logic [15:0] ext_data,
  output logic        ext_ready,
  input  logic [15:0] x_fb,
  output logic        check,
  output logic [1:0]  sw,
  output logic [15:0] word_out,
  output logic        busy,
  output logic [1:0]  nib_idx,
  output logic        done,
  output logic        timeout
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES);

  logic [2:0] btn_raw;
  logic [2:0] unused_level;
  logic [2:0] btn_p;
  logic       start_p, next_p, abort_p;

  assign btn_raw = {btn_abort, btn_next, btn_start};

  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_raw[i]),
      .level   (unused_level[i]),
      .rise_p  (btn_p[i])
    );
  end

  assign start_p = btn_p[0];
  assign next_p  = btn_p[1];
  assign abort_p = btn_p[2];

  entry_state_t  state, state_n;
  logic [1:0]    nib_n;
  logic [TW-1:0] tmo_cnt, tmo_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      nib_idx <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      nib_idx <= nib_n;
      tmo_cnt <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    nib_n     = nib_idx;
    tmo_n     = tmo_cnt;
    check     = 1'b0;
    sw        = nib_idx;
    word_out  = x_fb;       // feedback holds the register
    busy      = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    ext_ready = 1'b0;
    case (state)
      IDLE: begin
        // External load wins; a coincident start is dropped.
        if (ext_valid) begin
          ext_ready = 1'b1;
          word_out  = ext_data;
        end else if (start_p) begin
          state_n = ENTRY;
          nib_n   = '0;
          tmo_n   = '0;
        end
      end
      ENTRY: begin
        busy = 1'b1;
        if (abort_p) begin
          state_n = IDLE;
        end else if (next_p) begin
          check = 1'b1;
          tmo_n = '0;
          if (nib_idx == 2'(NIBBLES - 1)) state_n = DONE;
          else                            nib_n   = nib_idx + 2'd1;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_cnt + TW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        nib_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
